// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - instruction/data bus responder over one shared word RAM
module bus_mem_responder #(
  parameter int    ADDR_WIDTH = 12,
  parameter int    I_WAIT     = 0,
  parameter int    D_WAIT     = 0,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        istb,
  input  logic [29:0] iadr,
  output logic [31:0] idati,
  output logic        iack,
  input  logic        dstb,
  input  logic        dwe,
  input  logic [3:0]  dsel,
  input  logic [29:0] dadr,
  input  logic [31:0] ddato,
  output logic [31:0] ddati,
  output logic        dack
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [31:0] mem [DEPTH];

  // Upper address bits alias onto the implemented depth.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{iadr, dadr};

  state_t                  i_state, i_state_nx;
  logic [3:0]              i_cnt, i_cnt_nx;
  logic [ADDR_WIDTH-1:0]   i_adr_q, i_adr;
  logic                    i_do, i_lat;

  always_comb begin
    i_state_nx = i_state;
    i_cnt_nx   = i_cnt;
    i_do       = 1'b0;
    i_lat      = 1'b0;
    i_adr      = i_adr_q;
    case (i_state)
      IDLE: if (istb) begin
        if (I_WAIT == 0) begin
          i_do  = 1'b1;
          i_adr = iadr[ADDR_WIDTH-1:0];
        end else begin
          i_lat      = 1'b1;
          i_state_nx = BUSY;
          i_cnt_nx   = 4'(I_WAIT);
        end
      end
      BUSY: begin
        i_cnt_nx = i_cnt - 4'd1;
        if (i_cnt == 4'd1) begin
          i_do       = 1'b1;
          i_state_nx = IDLE;
        end
      end
      default: i_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_state <= IDLE;
      i_cnt   <= 4'd0;
      i_adr_q <= '0;
      iack    <= 1'b0;
      idati   <= 32'd0;
    end else begin
      i_state <= i_state_nx;
      i_cnt   <= i_cnt_nx;
      iack    <= i_do;
      if (i_lat) i_adr_q <= iadr[ADDR_WIDTH-1:0];
      if (i_do)  idati   <= mem[i_adr];
    end
  end

  state_t                  d_state, d_state_nx;
  logic [3:0]              d_cnt, d_cnt_nx;
  logic [ADDR_WIDTH-1:0]   d_adr_q, d_adr;
  logic                    d_we_q, d_we;
  logic [3:0]              d_sel_q, d_sel;
  logic [31:0]             d_dat_q, d_dat;
  logic                    d_do, d_lat;

  always_comb begin
    d_state_nx = d_state;
    d_cnt_nx   = d_cnt;
    d_do       = 1'b0;
    d_lat      = 1'b0;
    d_adr      = d_adr_q;
    d_we       = d_we_q;
    d_sel      = d_sel_q;
    d_dat      = d_dat_q;
    case (d_state)
      IDLE: if (dstb) begin
        if (D_WAIT == 0) begin
          d_do  = 1'b1;
          d_adr = dadr[ADDR_WIDTH-1:0];
          d_we  = dwe;
          d_sel = dsel;
          d_dat = ddato;
        end else begin
          d_lat      = 1'b1;
          d_state_nx = BUSY;
          d_cnt_nx   = 4'(D_WAIT);
        end
      end
      BUSY: begin
        d_cnt_nx = d_cnt - 4'd1;
        if (d_cnt == 4'd1) begin
          d_do       = 1'b1;
          d_state_nx = IDLE;
        end
      end
      default: d_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_state <= IDLE;
      d_cnt   <= 4'd0;
      d_adr_q <= '0;
      d_we_q  <= 1'b0;
      d_sel_q <= 4'd0;
      d_dat_q <= 32'd0;
      dack    <= 1'b0;
      ddati   <= 32'd0;
    end else begin
      d_state <= d_state_nx;
      d_cnt   <= d_cnt_nx;
      dack    <= d_do;
      if (d_lat) begin
        d_adr_q <= dadr[ADDR_WIDTH-1:0];
        d_we_q  <= dwe;
        d_sel_q <= dsel;
        d_dat_q <= ddato;
      end
      if (d_do && !d_we) ddati <= mem[d_adr];
    end
  end

  // Reset wins over a write scheduled for the same edge.
  always_ff @(posedge clk) begin
    if (!rst && d_do && d_we) begin
      for (int b = 0; b < 4; b++) begin
        if (d_sel[b]) mem[d_adr][8*b +: 8] <= d_dat[8*b +: 8];
      end
    end
  end

endmodule
